// File: rtl/regfile_load_sequencer_if.sv
// Board-side bus of the register-file load sequencer.
// Carries the raw buttons and switch byte in, and the register-file fields,
// write strobe and progress indicators out.
//   master : board / stimulus side (drives buttons and switches)
//   slave  : sequencer side (drives register-file fields and status)
interface regfile_load_sequencer_if;
    logic        btn_load;   // raw pushbutton, captures current field
    logic        btn_exec;   // raw pushbutton, commits the write
    logic [7:0]  data_in;    // switch value
    logic [31:0] wd3;        // register-file write data
    logic [4:0]  a1;         // read address 1
    logic [4:0]  a2;         // read address 2
    logic [4:0]  a3;         // write address
    logic        we3;        // one-cycle write enable
    logic [2:0]  field_idx;  // next field to capture
    logic [1:0]  state;      // 0 COLLECT, 1 ARMED, 2 WRITE, 3 DONE

    modport master (
        output btn_load, btn_exec, data_in,
        input  wd3, a1, a2, a3, we3, field_idx, state
    );

    modport slave (
        input  btn_load, btn_exec, data_in,
        output wd3, a1, a2, a3, we3, field_idx, state
    );
endinterface

// File: rtl/regfile_load_sequencer.sv
// Register-file load sequencer.
// Debounces two raw pushbuttons and steps through seven fields (wd3 bytes
// 0-3, a1, a2, a3) captured from the switches, then issues a single-cycle
// write strobe on an exec press.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of regfile_load_sequencer_if (buttons, switches in;
//           wd3/a1/a2/a3/we3/field_idx/state out)
module regfile_load_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input logic                      clk,
    input logic                      rst_n,
    regfile_load_sequencer_if.slave  bus
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StCollect = 2'd0,
        StArmed   = 2'd1,
        StWrite   = 2'd2,
        StDone    = 2'd3
    } state_e;

    // Button index 0 = load, 1 = exec.
    logic [1:0]      raw;
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0]      stable_q, stable_d;
    logic [1:0]      stable_dly_q;
    logic [CntW-1:0] cnt_q [2];
    logic [CntW-1:0] cnt_d [2];
    logic [1:0]      press;

    state_e      state_q, state_d;
    logic [2:0]  field_idx_q, field_idx_d;
    logic [31:0] wd3_q, wd3_d;
    logic [4:0]  a1_q, a1_d;
    logic [4:0]  a2_q, a2_d;
    logic [4:0]  a3_q, a3_d;
    logic        we3_q, we3_d;

    logic load_ev, exec_ev;

    assign raw = {bus.btn_exec, bus.btn_load};

    // Debounce: the stable level only follows after DEBOUNCE_CYCLES consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]    = '0;
            stable_d[i] = stable_q[i];
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // Rising edge of the stable level only; releases never produce events.
    assign press   = stable_q & ~stable_dly_q;
    assign load_ev = press[0];
    assign exec_ev = press[1];

    always_comb begin
        state_d     = state_q;
        field_idx_d = field_idx_q;
        wd3_d       = wd3_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        a3_d        = a3_q;

        unique case (state_q)
            StCollect: begin
                if (load_ev) begin
                    field_idx_d = field_idx_q + 3'd1;
                    case (field_idx_q)
                        3'd0, 3'd1, 3'd2, 3'd3: wd3_d[{field_idx_q[1:0], 3'b000} +: 8] = bus.data_in;
                        3'd4: a1_d = bus.data_in[4:0];
                        3'd5: a2_d = bus.data_in[4:0];
                        3'd6: begin
                            a3_d        = bus.data_in[4:0];
                            field_idx_d = 3'd0;
                            state_d     = StArmed;
                        end
                        default: field_idx_d = 3'd0;
                    endcase
                end
            end
            StArmed: begin
                if (exec_ev) begin
                    state_d = StWrite;
                end else if (load_ev) begin
                    state_d     = StCollect;
                    field_idx_d = 3'd0;
                end
            end
            // Events landing in the strobe cycle are intentionally dropped.
            StWrite: state_d = StDone;
            StDone: begin
                if (exec_ev) begin
                    state_d = StWrite;
                end else if (load_ev) begin
                    wd3_d[7:0]  = bus.data_in;
                    field_idx_d = 3'd1;
                    state_d     = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase

        // Registered strobe: high exactly while the FSM sits in WRITE.
        we3_d = (state_d == StWrite);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= '0;
            end
            state_q     <= StCollect;
            field_idx_q <= 3'd0;
            wd3_q       <= 32'd0;
            a1_q        <= 5'd0;
            a2_q        <= 5'd0;
            a3_q        <= 5'd0;
            we3_q       <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q     <= state_d;
            field_idx_q <= field_idx_d;
            wd3_q       <= wd3_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            a3_q        <= a3_d;
            we3_q       <= we3_d;
        end
    end

    assign bus.wd3       = wd3_q;
    assign bus.a1        = a1_q;
    assign bus.a2        = a2_q;
    assign bus.a3        = a3_q;
    assign bus.we3       = we3_q;
    assign bus.field_idx = field_idx_q;
    assign bus.state     = state_q;

endmodule

// File: doc/regfile_load_sequencer.md
Name: regfile_load_sequencer

Overview:
- Synchronous front-end controller that sequences loading of the 32-bit register-file checker from board switches and two pushbuttons.
- Debounces the buttons and steps through seven fields in a fixed order: wd3 bytes 0-3, then a1, a2, a3.
- Issues a single-cycle write strobe to the register file on command.
- Sits between the board I/O (switches, buttons, LEDs) and the register file; replaces select-driven manual field capture.

Parameters:
- DEBOUNCE_CYCLES, 250000, number of consecutive cycles a synchronized button level must differ from the stable level before it is accepted (5 ms at 50 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn_load  input  1  raw pushbutton, active-high, asynchronous; captures the current field.
- btn_exec  input  1  raw pushbutton, active-high, asynchronous; commits the write.
- data_in  input  8  switch value, sampled on an accepted load press.
- wd3  output  32  register-file write data.
- a1  output  5  register-file read address 1.
- a2  output  5  register-file read address 2.
- a3  output  5  register-file write address.
- we3  output  1  register-file write enable; one-cycle pulse.
- field_idx  output  3  next field to capture: 0-3 = wd3 byte 0-3, 4 = a1, 5 = a2, 6 = a3.
- state  output  2  0 COLLECT, 1 ARMED, 2 WRITE, 3 DONE.

Behaviour:
- Reset (async assert, sync release): wd3 = 0, a1 = a2 = a3 = 0, we3 = 0, field_idx = 0, state = COLLECT. Debounce counters = 0, stable levels = 0, synchronizer flops = 0.
- Button conditioning, per button, independent:
  - 2-flop synchronizer feeding the debouncer.
  - Counter increments while the synchronized level differs from the stable level. It clears when the two are equal.
  - When the counter = DEBOUNCE_CYCLES-1 and the levels still differ, the stable level takes the synchronized value and the counter clears.
  - Press event = stable level rising versus its 1-cycle delayed copy. It lasts exactly one cycle and is acted on at the next edge.
  - Release and bounce never generate events.
  - Latency from the first edge sampling raw high to the FSM action edge: DEBOUNCE_CYCLES+3 edges.
- COLLECT, on a load event:
  - Field field_idx takes data_in. Bytes write wd3[8k+7:8k] for k = field_idx. Address fields take data_in[4:0]; data_in[7:5] is ignored.
  - field_idx increments.
  - Capturing field 6 sets field_idx to 0 and moves to ARMED in the same edge.
  - Exec events in COLLECT are ignored.
- ARMED:
  - Exec event: go to WRITE.
  - Load event: go back to COLLECT with field_idx = 0. Register contents are kept (re-edit).
  - Simultaneous load and exec events: exec wins.
- WRITE: we3 = 1 for exactly this one cycle, then unconditionally go to DONE. Button events arriving in this cycle are dropped.
- DONE:
  - Outputs hold. a1 and a2 stay driven so the register file read-back is visible.
  - Load event: capture data_in into field 0, set field_idx = 1, go to COLLECT (starts a new transaction).
  - Exec event: go to WRITE (rewrite the same data).
- we3 is 0 in every state except WRITE. It is registered: it is high during the cycle after the edge that enters WRITE.
- Outputs change only at the edges listed above. data_in changes at any other time have no effect.
- Reset mid-operation, including during WRITE: everything returns to reset values immediately and we3 drops asynchronously. Partially collected fields are discarded.
- Button held high indefinitely produces one event only. A new event needs a release longer than DEBOUNCE_CYCLES, then a new press.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset check: assert rst_n low mid-clock -> all outputs 0 and state = 0 before the next edge.
- Full sequence:
  - Stimulus: load presses with data_in = 0x78, 0x56, 0x34, 0x12, 0x03, 0x05, 0xE7; then an exec press.
  - Response: wd3 = 0x12345678, a1 = 3, a2 = 5, a3 = 7; state = ARMED after the 7th press; we3 high exactly one cycle; state = DONE.
- Bounce rejection: btn_load toggling every 2 cycles for 20 cycles, then stable high 10 cycles -> exactly one capture, field_idx 0 -> 1. The capture edge is 7 edges after stable high is first sampled.
- Ignored and priority events:
  - Exec press in COLLECT -> no state change and we3 stays 0.
  - Load and exec pressed simultaneously in ARMED -> WRITE taken.
  - Load alone in ARMED -> COLLECT, field_idx = 0, wd3 unchanged.
- DONE paths:
  - Exec in DONE -> second one-cycle we3 pulse with unchanged data.
  - Load with data_in = 0xAA in DONE -> wd3[7:0] = 0xAA, field_idx = 1, state = COLLECT.
- Reset mid-collect: after 3 captures, pulse rst_n -> field_idx = 0, wd3 = 0, no we3 pulse.
